// File: rtl/dpram_stream_reader_if.sv
// Bundle of command, RAM read port and output stream signals for dpram_stream_reader.
// master = the reader, slave = the surrounding RAM / command source / consumer.
interface dpram_stream_reader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rdata, rvalid, out_ready,
    output cmd_ready, araddr, arvalid, out_data, out_valid, out_last, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rdata, rvalid, out_ready,
    input  cmd_ready, araddr, arvalid, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/dpram_stream_reader.sv
// Burst reader for a fixed-latency dpram: issues one read per word and streams the
// results out through a 2-entry FIFO, issuing only when the FIFO is guaranteed room.
//
// state   | meaning
// S_IDLE  | waiting for a command (cmd_ready high once out of reset)
// S_ISSUE | issuing reads while credit allows, until all words are requested
// S_DRAIN | all reads issued, waiting for the last word to be taken
module dpram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic i_clk,
  input  logic i_rst,
  dpram_stream_reader_if.master io_rd
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_live;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH:0]   r_fifo [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  r_done;

  logic                  w_cmd_accept;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_last_hs;
  logic                  w_final_read;
  logic [DATA_WIDTH:0]   w_head;

  assign w_head       = r_fifo[r_rd_ptr];
  assign w_cmd_accept = io_rd.cmd_valid & io_rd.cmd_ready;
  assign w_pop        = (r_count != 2'd0) & io_rd.out_ready;
  assign w_push       = r_inflight & io_rd.rvalid;
  assign w_credit     = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2;
  assign w_final_read = (r_remain == LEN_WIDTH'(1));
  assign w_last_hs    = (r_state == S_DRAIN) & w_pop & w_head[DATA_WIDTH];

  assign io_rd.cmd_ready = (r_state == S_IDLE) & r_live;
  assign io_rd.arvalid   = w_issue;
  assign io_rd.araddr    = r_addr;
  assign io_rd.out_valid = (r_count != 2'd0);
  assign io_rd.out_data  = w_head[DATA_WIDTH-1:0];
  assign io_rd.out_last  = w_head[DATA_WIDTH] & (r_count != 2'd0);
  assign io_rd.done      = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_accept && (io_rd.cmd_len != '0)) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // a same-cycle pop frees the slot the new word will need two cycles later
        w_issue = w_credit | w_pop;
        if (w_issue && w_final_read) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_live          <= 1'b0;
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_live          <= 1'b1;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_final_read;
      r_done          <= (w_cmd_accept && (io_rd.cmd_len == '0)) || w_last_hs;
      if (w_cmd_accept) begin
        r_addr   <= io_rd.cmd_addr;
        r_remain <= io_rd.cmd_len;
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_remain <= r_remain - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {r_inflight_last, io_rd.rdata};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: a 1-cycle RAM model, directed and random bursts,
// and a queue-based reference of the expected address and word streams.
module tb_dpram_stream_reader;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 11;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stray_req = 1'b0;
  int   rdy_mode = 0;
  logic rdy_force = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  dpram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  dpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_rd (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    bus.rvalid <= bus.arvalid | stray_req;
    bus.rdata  <= stray_req ? 64'hBAD0_BAD0_BAD0_BAD0 : mem[bus.araddr];
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = rdy_force;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  word_t         exp_q [$];
  logic [AW-1:0] addr_q [$];
  logic          exp_done = 1'b0;
  int            issued = 0, popped = 0, hs_cnt = 0, done_cnt = 0;
  int            cyc_acc = 0, first_ar = -1, first_ov = -1, cyc_done = -1;

  always @(negedge clk) begin
    logic  nxt_done;
    word_t w;
    int    a;
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      exp_done = 1'b0;
      issued   = 0;
      popped   = 0;
    end else begin
      nxt_done = 1'b0;
      chk("done", bus.done, exp_done);
      if (bus.done) begin
        done_cnt++;
        cyc_done = cyc;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        cyc_acc  = cyc;
        first_ar = -1;
        first_ov = -1;
        for (int i = 0; i < int'(bus.cmd_len); i++) begin
          a = (int'(bus.cmd_addr) + i) % DEPTH;
          addr_q.push_back(AW'(a));
          w.d = mem[a];
          w.l = (i == int'(bus.cmd_len) - 1);
          exp_q.push_back(w);
        end
        if (bus.cmd_len == '0) nxt_done = 1'b1;
      end
      chk("credit", 64'((issued - popped) <= 2), 64'd1);
      if (bus.arvalid) begin
        if (first_ar < 0) first_ar = cyc;
        if (addr_q.size() > 0) chk("araddr", 64'(bus.araddr), 64'(addr_q.pop_front()));
        else chk("ar_spurious", 64'(bus.arvalid), 64'd0);
        issued++;
      end
      if (exp_q.size() > 0) begin
        if (bus.out_valid) begin
          if (first_ov < 0) first_ov = cyc;
          chk("out_data", bus.out_data, exp_q[0].d);
          chk("out_last", 64'(bus.out_last), 64'(exp_q[0].l));
          if (bus.out_ready) begin
            if (exp_q[0].l) nxt_done = 1'b1;
            void'(exp_q.pop_front());
            popped++;
            hs_cnt++;
          end
        end
      end else begin
        chk("out_spurious", 64'(bus.out_valid), 64'd0);
      end
      exp_done = nxt_done;
    end
  end

  task automatic send_cmd(input int base, input int len);
    int t;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(base);
    bus.cmd_len   = LW'(len);
    t = 0;
    while (!bus.cmd_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("cmd_accept_timeout", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int tmo);
    int start, t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < tmo) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", 64'(done_cnt != start), 64'd1);
    repeat (3) @(posedge clk);
    chk("done_once", 64'(done_cnt - start), 64'd1);
    chk("words_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_timing(input int len);
    chk("t_first_ar", 64'(first_ar), 64'(cyc_acc + 1));
    chk("t_first_ov", 64'(first_ov), 64'(cyc_acc + 3));
    chk("t_done", 64'(cyc_done), 64'(cyc_acc + 3 + len));
  endtask

  task automatic check_reset_vals();
    chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("rst_araddr", 64'(bus.araddr), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
  endtask

  task automatic run_burst(input int base, input int len, input bit timed);
    send_cmd(base, len);
    wait_done(len * 20 + 50);
    if (timed) check_timing(len);
  endtask

  initial begin
    int start, t;
    logic pat [14];
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(3 * i);

    // power-on reset and release
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    chk("rdy_before_edge", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", 64'(bus.cmd_ready), 64'd1);

    run_burst(16, 4, 1'b1);
    run_burst(1022, 4, 1'b1);

    send_cmd(0, 0);
    chk("zero_rdy_kept", 64'(bus.cmd_ready), 64'd1);
    wait_done(20);
    chk("zero_t_done", 64'(cyc_done), 64'(cyc_acc + 1));

    // backpressure pattern 1,0,1,0 then ten stalled cycles
    rdy_mode = 2;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rdy_force = 1'b1;
    send_cmd(40, 8);
    for (int i = 0; i < 14; i++) begin
      rdy_force = pat[i];
      @(posedge clk); #1;
    end
    rdy_force = 1'b1;
    wait_done(100);
    rdy_mode = 0;

    // reset in the middle of a burst, then a stray read response
    start = hs_cnt;
    send_cmd(200, 16);
    t = 0;
    while ((hs_cnt - start) < 5 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_words_seen", 64'((hs_cnt - start) >= 5), 64'd1);
    start = done_cnt;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_rdy_low", 64'(bus.cmd_ready), 64'd0);
    stray_req = 1'b1;
    @(posedge clk); #1;
    stray_req = 1'b0;
    chk("rel_rdy_high", 64'(bus.cmd_ready), 64'd1);
    repeat (3) @(posedge clk);
    chk("no_done_after_abort", 64'(done_cnt - start), 64'd0);
    run_burst(256, 2, 1'b1);

    run_burst(0, 1024, 1'b1);

    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    rdy_mode = 1;
    for (int k = 0; k < 16; k++) begin
      run_burst($urandom_range(0, DEPTH - 1),
                (k == 7) ? 1100 : $urandom_range(0, 24), 1'b0);
    end
    rdy_mode = 0;
    run_burst($urandom_range(0, DEPTH - 1), 5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Read-side initiator for the single-read-port `dpram`. It accepts a burst command (base address, word count) and issues one `ARADDR`/`ARVALID` read per word. It captures each `RDATA`/`RVALID` response and streams the words out on a valid/ready interface with last-word marking. Because the RAM cannot stall, the block absorbs downstream backpressure with credit-limited issue and a 2-entry output FIFO. It sits between a buffet/RAM instance and any consumer that needs flow control.

## Interface
- `ADDR_WIDTH`, 10, RAM address width; must match the attached `dpram`.
- `DATA_WIDTH`, 64, RAM word width; must match the attached `dpram`.
- `LEN_WIDTH`, `ADDR_WIDTH+1`, command length width; allows a full-memory burst.
- `CLK`  in  1  single clock for all logic.
- `RESET`  in  1  asynchronous reset, active-high.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  command accepted when high together with `CMD_VALID`.
- `CMD_ADDR`  in  `ADDR_WIDTH`  burst base address.
- `CMD_LEN`  in  `LEN_WIDTH`  number of words to read; 0 is legal.
- `ARADDR`  out  `ADDR_WIDTH`  RAM read address.
- `ARVALID`  out  1  RAM read strobe.
- `RDATA`  in  `DATA_WIDTH`  RAM read data.
- `RVALID`  in  1  RAM read data valid; arrives exactly 1 cycle after `ARVALID`.
- `OUT_DATA`  out  `DATA_WIDTH`  streamed word.
- `OUT_VALID`  out  1  `OUT_DATA` is valid.
- `OUT_READY`  in  1  consumer accepts the word.
- `OUT_LAST`  out  1  marks the final word of the burst; qualified by `OUT_VALID`.
- `DONE`  out  1  single-cycle pulse when a burst has fully completed.

## Operation
- **FSM states and transitions:**
  - IDLE: `CMD_READY`=1. On command accept with `CMD_LEN`≠0, go to ISSUE. With `CMD_LEN`=0, stay in IDLE and pulse `DONE` the next cycle.
  - ISSUE: issue reads until all `CMD_LEN` reads are issued, then go to DRAIN.
  - DRAIN: wait for the `OUT_LAST` handshake, then go to IDLE.
  - No command overlap: `CMD_READY` is 0 in ISSUE and DRAIN.
- **Address counter:** loads `CMD_ADDR` and increments after each issued read, modulo 2^`ADDR_WIDTH`. A burst crossing the top address wraps to 0. `CMD_LEN` > 2^`ADDR_WIDTH` re-reads wrapped addresses.
- **Remaining counter:** `LEN_WIDTH` bits, loaded with `CMD_LEN` and decremented per issued read. The read issued when the counter equals 1 carries the last tag.
- **Issue rule:** in ISSUE, drive `ARVALID`=1 when either condition holds:
  - FIFO occupancy + in-flight count < 2, or
  - an output handshake (`OUT_VALID`&`OUT_READY`) occurs this cycle.
  - There is at most 1 read in flight.
- **In-flight tracking:**
  - An internal flag holds the `ARVALID` registered one cycle; a second register holds the last tag.
  - Push into the FIFO when flag & `RVALID`, storing {last tag, `RDATA`}.
  - `RVALID` without the flag set (stray, e.g. after a reset) is ignored.
- **Output FIFO:** 2 entries, registered storage.
  - `OUT_VALID` = occupancy≠0. `OUT_DATA` and `OUT_LAST` come from the head entry.
  - Push and pop in the same cycle are legal.
  - The credit rule guarantees a push never overflows the FIFO.
- **Ordering:** words leave in address order, each exactly once. Data is never lost under any `OUT_READY` pattern.
- **DONE:** a registered pulse in the cycle after the `OUT_LAST` handshake, in the same cycle the FSM re-enters IDLE.

## Timing
- **Reset values:** asserting `RESET` immediately and asynchronously forces:
  - `ARVALID`=0, `ARADDR`=0, `OUT_VALID`=0, `OUT_DATA`=0, `OUT_LAST`=0, `DONE`=0, `CMD_READY`=0;
  - FSM to IDLE, FIFO emptied, in-flight flag cleared.
- **After reset:** `CMD_READY` goes to 1 on the first `CLK` edge after `RESET` falls.
- **Burst latency** (command accepted in cycle c):
  - `ARVALID` with `ARADDR`=base in cycle c+1.
  - `RVALID` in cycle c+2.
  - First `OUT_VALID` in cycle c+3.
- **Throughput:** with `OUT_READY` held high, one word per cycle. Reads are issued in c+1..c+LEN, the last word is output in c+2+LEN, and `DONE`/`CMD_READY`=1 arrive in c+3+LEN.
- **Backpressure:** with `OUT_READY` low, issue stops once 2 words are buffered or in flight. `OUT_DATA` and `OUT_LAST` hold stable while `OUT_VALID`&~`OUT_READY`. Issue resumes in the same cycle `OUT_READY` handshakes.
- **Reset mid-burst:** the burst is abandoned with no `DONE`. The next command starts cleanly.

## Test plan
- **Basic burst:** RAM mem[i]=3i, command base 0x010 LEN 4, `OUT_READY`=1 -> `ARADDR` 0x010..0x013 in c+1..c+4. `OUT_DATA` 0x30,0x33,0x36,0x39 in c+3..c+6, `OUT_LAST` only on 0x39, `DONE` at c+7.
- **Address wrap:** base 0x3FE LEN 4 -> `ARADDR` sequence 0x3FE,0x3FF,0x000,0x001; data matches those four locations in order.
- **Backpressure:** LEN 8 with `OUT_READY` pattern 1,0,1,0, then low for 10 cycles, then high -> never more than 2 words buffered or in flight. All 8 words arrive in order with no duplicates, and data stays stable while stalled.
- **Zero length:** LEN 0 -> no `ARVALID`, no `OUT_VALID`, `DONE` one cycle after accept, `CMD_READY` remains 1.
- **Reset mid-burst:** LEN 16, assert `RESET` after 5 output words, inject a stray `RVALID` the cycle after release -> outputs take reset values immediately and the stray word is dropped. A following LEN 2 command at 0x100 yields exactly mem[0x100] and mem[0x101].
- **Full memory:** base 0 LEN 1024 -> 1024 words 0x000..0x3FF, `OUT_LAST` only on word 1024, `DONE` once.
